mux_sel_sched_l1: RTL
=====================

MUX_SEL_SCHED_L1 -- requirements
Module: mux_sel_sched_l1

Interface
REQ-001 SHALL have parameter DATA_W, default 8, lane data width in bits.
REQ-002 SHALL have port clk_2f  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port valid_in  in  4  per-lane request, bit i = lane i.
REQ-005 SHALL have ports data_in0..data_in3  in  DATA_W each  lane payloads.
REQ-006 SHALL have port ready_out  out  4  per-lane accept; a transfer occurs when valid_in[i] and ready_out[i] are both high at a clock edge.
REQ-007 SHALL have port selectorL1  out  1  group served: 0 = lanes {0,1}, 1 = lanes {2,3}.
REQ-008 SHALL have ports validout0, validout1  out  1 each  valid for the even or odd lane of the served group.
REQ-009 SHALL have ports dataout0_muxL1, dataout1_muxL1  out  DATA_W each  payload of the even or odd lane of the served group.

Function
REQ-010 SHALL hold one entry per lane (hold_v[i], hold_d[i]); pending group flags: p0 = hold_v[0]|hold_v[1], p1 = hold_v[2]|hold_v[3].
REQ-011 SHALL drive ready_out[i] = ~hold_v[i] | grant[i]; this is combinational from registered state only, with no dependency on valid_in.
REQ-012 SHALL use an FSM with states IDLE, SERV0, SERV1; the state names the group granted in the current cycle.
REQ-013 SHALL compute the next state as follows: next-cycle p0 and p1 both set -> group opposite the current one (IDLE counts as after group 1); only p0 -> SERV0; only p1 -> SERV1; neither -> IDLE.
REQ-014 SHALL, in SERVg, grant every lane of group g whose hold_v is set; both lanes of a group may be granted in the same cycle.
REQ-015 SHALL register outputs at the edge ending the grant cycle: selectorL1 = g, validout0 = hold_v[2g], validout1 = hold_v[2g+1], with data copied from the granted entries.
REQ-016 SHALL drive dataoutN to 0 whenever validoutN is 0; in IDLE, validout0/1 = 0 and selectorL1 keeps its last value.
REQ-017 SHALL give a latency of exactly 2 edges from capture to output when there is no contention: capture at edge k, grant in cycle k..k+1, output valid after edge k+1.
REQ-018 SHALL, when a lane is granted and a new valid_in arrives in the same cycle, reload that lane's entry with no bubble.
REQ-019 SHALL hold valid_in with ready_out low without loss; the requester holds its data stable until accepted.
REQ-020 SHALL, with all four lanes continuously valid, alternate selectorL1 0,1,0,1..., giving each lane 1 transfer per 2 cycles.

Reset
REQ-021 SHALL, while reset = 1 (asynchronous), force: hold_v = 0, hold_d = 0, state = IDLE, selectorL1 = 0, validout0/1 = 0, dataout0/1_muxL1 = 0, and ready_out = 4'b1111.
REQ-022 SHALL discard in-flight entries on reset mid-operation; after release, the first contended grant goes to group 0.

Configuration
REQ-023 SHALL support macro MUX_SCHED_CNT_EN.
REQ-024 SHALL, when MUX_SCHED_CNT_EN is defined, add outputs cnt_grp0 and cnt_grp1 (out, 16 bits each) counting SERV0 and SERV1 cycles; the counters reset to 0, wrap from 0xFFFF to 0, and saturation is not used.
REQ-025 SHALL, when MUX_SCHED_CNT_EN is undefined, omit the counter ports and logic entirely, leaving behaviour otherwise identical.

Structure
REQ-026 SHALL place the state encoding (IDLE = 2'd0, SERV0 = 2'd1, SERV1 = 2'd2), the group-to-lane mapping constants and the DATA_W default in shared package mux_l1_pkg.
REQ-027 SHALL implement the per-lane holding register as sub-module mux_l1_lane_hold, instanced 4 times; the FSM and output register stay in the top level.

Verification
REQ-028 SHALL check: reset asserted mid-stream with all lanes holding data -> all outputs 0 and ready_out = 4'b1111 immediately (no clock edge needed); no stale data appears after release.
REQ-029 SHALL check: single pulse valid_in = 4'b0001, data_in0 = 8'hA5 -> after 2 edges selectorL1 = 0, validout0 = 1, dataout0_muxL1 = 8'hA5, validout1 = 0; IDLE on the next cycle.
REQ-030 SHALL check: valid_in = 4'b1111 held for 8 cycles with incrementing data -> selectorL1 sequence 0,1,0,1...; no data dropped or duplicated; ready_out toggles per group.
REQ-031 SHALL check: only lanes 2 and 3 valid continuously (8'h33, 8'h44) -> selectorL1 stays 1, both validouts = 1 every cycle after the first 2, ready_out[3:2] = 2'b11 throughout.
REQ-032 SHALL check: lane 1 valid while group 1 is being served and lane 1 already holds data -> ready_out[1] = 0 until SERV0; the data held stable is delivered once.
REQ-033 SHALL check, with MUX_SCHED_CNT_EN: 10 SERV0 cycles and 6 SERV1 cycles -> cnt_grp0 = 10, cnt_grp1 = 6; preload 0xFFFF plus one grant -> 0.

Source files
------------

// File: rtl/mux_l1_pkg.sv
// mux_l1_pkg: shared state encoding, lane/group mapping and defaults for the
// two-group L1 lane scheduler (mux_sel_sched_l1).
package mux_l1_pkg;

    // Default lane payload width.
    localparam int unsigned DATA_W_DEFAULT = 8;

    // Four lanes, split into two groups of two.
    localparam int unsigned NUM_LANES = 4;

    // Width of the optional per-group service counters.
    localparam int unsigned CNT_W = 16;

    // The state names the group granted in the current cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERV0 = 2'd1,
        SERV1 = 2'd2
    } sched_state_t;

    // Group g owns lanes 2g (even output) and 2g+1 (odd output).
    localparam int unsigned GRP0_EVEN = 0;
    localparam int unsigned GRP0_ODD  = 1;
    localparam int unsigned GRP1_EVEN = 2;
    localparam int unsigned GRP1_ODD  = 3;

    localparam logic [NUM_LANES-1:0] GRP0_MASK = 4'b0011;
    localparam logic [NUM_LANES-1:0] GRP1_MASK = 4'b1100;

    // Lanes eligible for a grant in a given state.
    function automatic logic [NUM_LANES-1:0] grant_mask(input sched_state_t st);
        logic [NUM_LANES-1:0] m;
        unique case (st)
            SERV0:   m = GRP0_MASK;
            SERV1:   m = GRP1_MASK;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mux_l1_lane_hold.sv
// mux_l1_lane_hold: single-entry holding register for one request lane.
// Accepts a new payload whenever the entry is empty or is being drained by a
// grant in the same cycle, so a granted lane reloads without a bubble.
module mux_l1_lane_hold
    import mux_l1_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              grant,
    output logic              ready,
    output logic              hold_v,
    output logic              hold_v_nxt,
    output logic [DATA_W-1:0] hold_d
);

    logic accept;

    // Ready depends only on registered state and the grant, never on valid_in.
    always_comb begin
        ready      = ~hold_v | grant;
        accept     = valid_in & ready;
        hold_v_nxt = accept | (hold_v & ~grant);
    end

    // Entry update: load on accept, otherwise drain on grant.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            hold_v <= 1'b0;
            hold_d <= '0;
        end else if (accept) begin
            hold_v <= 1'b1;
            hold_d <= data_in;
        end else if (grant) begin
            hold_v <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_sel_sched_l1.sv
// mux_sel_sched_l1: schedules four request lanes onto a two-wide output by
// alternating between lane groups {0,1} and {2,3}. Each lane has a one-entry
// holding register; a three-state FSM picks the group served each cycle and
// the served group's entries are registered onto the outputs.
// Optional build macro MUX_SCHED_CNT_EN adds 16-bit wrapping counters of the
// cycles spent serving each group (cnt_grp0, cnt_grp1).
module mux_sel_sched_l1
    import mux_l1_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [3:0]        valid_in,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    output logic [3:0]        ready_out,
`ifdef MUX_SCHED_CNT_EN
    output logic [15:0]       cnt_grp0,
    output logic [15:0]       cnt_grp1,
`endif
    output logic              selectorL1,
    output logic              validout0,
    output logic              validout1,
    output logic [DATA_W-1:0] dataout0_muxL1,
    output logic [DATA_W-1:0] dataout1_muxL1
);

    sched_state_t state;
    sched_state_t state_nxt;

    logic [DATA_W-1:0]    lane_din [NUM_LANES];
    logic [DATA_W-1:0]    hold_d   [NUM_LANES];
    logic [NUM_LANES-1:0] hold_v;
    logic [NUM_LANES-1:0] hold_v_nxt;
    logic [NUM_LANES-1:0] grant;
    logic                 p0_nxt;
    logic                 p1_nxt;

    // Gather the lane payloads into an indexable array.
    always_comb begin
        lane_din[0] = data_in0;
        lane_din[1] = data_in1;
        lane_din[2] = data_in2;
        lane_din[3] = data_in3;
    end

    // Grant every occupied lane of the group named by the current state.
    always_comb begin
        grant = hold_v & grant_mask(state);
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mux_l1_lane_hold #(
            .DATA_W (DATA_W)
        ) u_lane_hold (
            .clk_2f     (clk_2f),
            .reset      (reset),
            .valid_in   (valid_in[i]),
            .data_in    (lane_din[i]),
            .grant      (grant[i]),
            .ready      (ready_out[i]),
            .hold_v     (hold_v[i]),
            .hold_v_nxt (hold_v_nxt[i]),
            .hold_d     (hold_d[i])
        );
    end

    // Next group: alternate under contention (IDLE behaves as after group 1),
    // otherwise serve whichever group will have pending entries.
    always_comb begin
        p0_nxt = hold_v_nxt[GRP0_EVEN] | hold_v_nxt[GRP0_ODD];
        p1_nxt = hold_v_nxt[GRP1_EVEN] | hold_v_nxt[GRP1_ODD];
        unique case ({p1_nxt, p0_nxt})
            2'b11:   state_nxt = (state == SERV0) ? SERV1 : SERV0;
            2'b01:   state_nxt = SERV0;
            2'b10:   state_nxt = SERV1;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and registered outputs for the group granted this cycle.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            selectorL1     <= 1'b0;
            validout0      <= 1'b0;
            validout1      <= 1'b0;
            dataout0_muxL1 <= '0;
            dataout1_muxL1 <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                SERV0: begin
                    selectorL1     <= 1'b0;
                    validout0      <= hold_v[GRP0_EVEN];
                    validout1      <= hold_v[GRP0_ODD];
                    dataout0_muxL1 <= hold_v[GRP0_EVEN] ? hold_d[GRP0_EVEN] : '0;
                    dataout1_muxL1 <= hold_v[GRP0_ODD]  ? hold_d[GRP0_ODD]  : '0;
                end
                SERV1: begin
                    selectorL1     <= 1'b1;
                    validout0      <= hold_v[GRP1_EVEN];
                    validout1      <= hold_v[GRP1_ODD];
                    dataout0_muxL1 <= hold_v[GRP1_EVEN] ? hold_d[GRP1_EVEN] : '0;
                    dataout1_muxL1 <= hold_v[GRP1_ODD]  ? hold_d[GRP1_ODD]  : '0;
                end
                default: begin
                    // selectorL1 keeps the last group served.
                    validout0      <= 1'b0;
                    validout1      <= 1'b0;
                    dataout0_muxL1 <= '0;
                    dataout1_muxL1 <= '0;
                end
            endcase
        end
    end

`ifdef MUX_SCHED_CNT_EN
    // Count cycles spent serving each group; plain wrap at 16 bits.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            cnt_grp0 <= '0;
            cnt_grp1 <= '0;
        end else begin
            if (state == SERV0) begin
                cnt_grp0 <= cnt_grp0 + CNT_W'(1);
            end
            if (state == SERV1) begin
                cnt_grp1 <= cnt_grp1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule
